// File: rtl/mem_stage_if.sv
// EX/MEM to MEM/WB bus for mem_stage. memErr exists only when MEM_ALIGN_CHECK_EN is defined.
interface mem_stage_if;
   logic [31:0] EXMEMIR;
   logic [31:0] EXMEMALUOut;
   logic [31:0] EXMEMB;
   logic        EXMEMFlagOut;
   logic        memStall;
   logic        ijmpMem;
   logic [31:0] ijmpTarget;
   logic [31:0] MEMWBValue;
   logic [31:0] MEMWBIR;
   logic        MEMWBFlag;
`ifdef MEM_ALIGN_CHECK_EN
   logic        memErr;

   modport master (
      output EXMEMIR, EXMEMALUOut, EXMEMB, EXMEMFlagOut,
      input  memStall, ijmpMem, ijmpTarget, MEMWBValue, MEMWBIR, MEMWBFlag, memErr
   );
   modport slave (
      input  EXMEMIR, EXMEMALUOut, EXMEMB, EXMEMFlagOut,
      output memStall, ijmpMem, ijmpTarget, MEMWBValue, MEMWBIR, MEMWBFlag, memErr
   );
`else
   modport master (
      output EXMEMIR, EXMEMALUOut, EXMEMB, EXMEMFlagOut,
      input  memStall, ijmpMem, ijmpTarget, MEMWBValue, MEMWBIR, MEMWBFlag
   );
   modport slave (
      input  EXMEMIR, EXMEMALUOut, EXMEMB, EXMEMFlagOut,
      output memStall, ijmpMem, ijmpTarget, MEMWBValue, MEMWBIR, MEMWBFlag
   );
`endif
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: multi-cycle data-memory LW/SW, IJMP redirect, MEM/WB latch.
// Optional MEM_ALIGN_CHECK_EN adds misaligned-access suppression and a sticky memErr.
module mem_stage #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned MEM_LAT = 2,
   parameter logic [5:0]  LW_OP   = 6'd35,
   parameter logic [5:0]  SW_OP   = 6'd43,
   parameter logic [5:0]  ALU_OP  = 6'd0,
   parameter logic [5:0]  CDEC_OP = 6'd20,
   parameter logic [5:0]  IJMP_OP = 6'd21,
   parameter logic [31:0] NOP_IR  = 32'h00000020
) (
   input logic        clk,
   input logic        reset,
   mem_stage_if.slave bus
);

   localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {StIdle, StAccess} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       value_q, value_d;
   logic [31:0]       ir_q, ir_d;
   logic              flag_q, flag_d;
   logic              err_q, err_d;

   logic [31:0]       mem [DEPTH];
   logic [5:0]        op;
   logic [ADDR_W-1:0] idx;
   logic              is_mem, misalign, stall, ijmp, complete, wr_en;
   logic [31:0]       load_val;
   logic              unused_bits;

   assign op     = bus.EXMEMIR[31:26];
   assign idx    = bus.EXMEMALUOut[ADDR_W+1:2];
   assign is_mem = (op == LW_OP) || (op == SW_OP);
   assign unused_bits = ^{bus.EXMEMIR[25:0], bus.EXMEMALUOut[31:ADDR_W+2],
                          bus.EXMEMALUOut[1:0], ALU_OP};

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = |bus.EXMEMALUOut[1:0];
   assign load_val = misalign ? 32'hDEADBEEF : mem[idx];
   assign bus.memErr = err_q;
`else
   assign misalign = 1'b0;
   assign load_val = mem[idx];
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      value_d  = value_q;
      ir_d     = bus.EXMEMIR;
      flag_d   = 1'b0;
      err_d    = err_q;
      stall    = 1'b0;
      ijmp     = 1'b0;
      complete = 1'b0;

      case (state_q)
         StIdle: begin
            if (is_mem) begin
               if (MEM_LAT == 1) begin
                  complete = 1'b1;
               end else begin
                  stall   = 1'b1;
                  state_d = StAccess;
                  cnt_d   = CNT_INIT;
               end
            end else if (op == IJMP_OP) begin
               ijmp = 1'b1;
            end
         end
         StAccess: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               complete = 1'b1;
               state_d  = StIdle;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Stalled cycles push a bubble into WB; the access retires on the completing edge.
      if (stall) begin
         ir_d = NOP_IR;
      end else if (complete) begin
         if (op == LW_OP) value_d = load_val;
         if (misalign) err_d = 1'b1;
      end else if (op == CDEC_OP) begin
         flag_d = bus.EXMEMFlagOut;
         if (bus.EXMEMFlagOut) value_d = bus.EXMEMALUOut;
      end else if (op != IJMP_OP) begin
         value_d = bus.EXMEMALUOut;
      end
   end

   assign wr_en          = complete && (op == SW_OP) && !misalign && !reset;
   assign bus.memStall   = stall && !reset;
   assign bus.ijmpMem    = ijmp && !reset;
   assign bus.ijmpTarget = bus.ijmpMem ? bus.EXMEMALUOut : 32'h0;
   assign bus.MEMWBValue = value_q;
   assign bus.MEMWBIR    = ir_q;
   assign bus.MEMWBFlag  = flag_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         value_q <= 32'h0;
         ir_q    <= NOP_IR;
         flag_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         value_q <= value_d;
         ir_q    <= ir_d;
         flag_q  <= flag_d;
         err_q   <= err_d;
      end
   end

   // Memory is never cleared by reset; a reset-aborted SW leaves it untouched.
   always_ff @(posedge clk) begin
      if (wr_en) mem[idx] <= bus.EXMEMB;
   end

endmodule
